// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the DMEM responder.
// Bit 0 is the MSB throughout, so byte lane 0 is the most significant byte.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    function automatic logic [0:3] byte_enables(input size_e size, input logic [1:0] offset);
        logic [0:3] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be[offset] = 1'b1;
            SZ_HALF: be = offset[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
        case (size)
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half lane out of a big-endian word and
// right-justifies it with sign or zero extension.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [0:31] word_i,
    input  size_e       size_i,
    input  logic [1:0]  offset_i,
    input  logic        sign_extend_i,
    output logic [0:31] data_o
);

    logic [0:7]  lane_b;
    logic [0:15] lane_h;
    logic [4:0]  base_b;
    logic [4:0]  base_h;

    always_comb begin
        base_b = {offset_i, 3'b000};
        base_h = {offset_i[1], 4'b0000};
        lane_b = word_i[base_b +: 8];
        lane_h = word_i[base_h +: 16];
        data_o = '0;
        case (size_i)
            SZ_BYTE: data_o = {{24{sign_extend_i & lane_b[0]}}, lane_b};
            SZ_HALF: data_o = {{16{sign_extend_i & lane_h[0]}}, lane_h};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// DMEM responder: captures one request, waits WAIT_CYCLES, then performs the
// access on the RESP edge and presents a one-cycle ready pulse with the result.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WORDS_LOG2 = 10,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_i,
    input  logic [0:31] addr_i,
    input  logic        write_enable_i,
    input  logic        byte_i,
    input  logic        half_word_i,
    input  logic        sign_extend_i,
    input  logic [0:31] data_in_i,
    output logic [0:31] data_out_o,
    output logic        ready_o,
    output logic        misaligned_o
);

    localparam int         DEPTH = 2 ** ADDR_WORDS_LOG2;
    localparam logic [3:0] WLAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e                     state_q;
    logic [3:0]                 wcnt_q;
    logic [ADDR_WORDS_LOG2-1:0] idx_q;
    logic [1:0]                 off_q;
    logic                       we_q;
    logic                       se_q;
    size_e                      size_q;
    logic [0:31]                wdata_q;
    logic [0:31]                data_out_q;
    logic                       ready_q;
    logic                       mis_q;
    logic [0:31]                mem_q [0:DEPTH-1];

    size_e       req_size_d;
    logic        mis_d;
    logic [0:3]  be_d;
    logic [0:31] rd_word_d;
    logic [0:31] ld_data_d;
    logic [0:31] st_word_d;
    logic        mem_we_d;

    // Bits above the word index alias onto the same words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[0:29-ADDR_WORDS_LOG2];

    always_comb begin
        req_size_d = byte_i ? SZ_BYTE : (half_word_i ? SZ_HALF : SZ_WORD);
        mis_d      = is_misaligned(size_q, off_q);
        be_d       = byte_enables(size_q, off_q);
        rd_word_d  = mem_q[idx_q];
        case (size_q)
            SZ_BYTE: st_word_d = {4{wdata_q[24:31]}};
            SZ_HALF: st_word_d = {2{wdata_q[16:31]}};
            default: st_word_d = wdata_q;
        endcase
        mem_we_d = (state_q == RESP) && we_q && !mis_d && !reset;
    end

    dmem_load_align u_align (
        .word_i        (rd_word_d),
        .size_i        (size_q),
        .offset_i      (off_q),
        .sign_extend_i (se_q),
        .data_o        (ld_data_d)
    );

    always_ff @(posedge clock) begin
        if (mem_we_d) begin
            for (int b = 0; b < 4; b++) begin
                if (be_d[b]) mem_q[idx_q][8*b +: 8] <= st_word_d[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            idx_q      <= '0;
            off_q      <= '0;
            we_q       <= 1'b0;
            se_q       <= 1'b0;
            size_q     <= SZ_WORD;
            wdata_q    <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            mis_q   <= 1'b0;
            case (state_q)
                IDLE: if (req_i) begin
                    idx_q   <= addr_i[30-ADDR_WORDS_LOG2:29];
                    off_q   <= addr_i[30:31];
                    we_q    <= write_enable_i;
                    se_q    <= sign_extend_i;
                    size_q  <= req_size_d;
                    wdata_q <= data_in_i;
                    wcnt_q  <= '0;
                    state_q <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
                WAIT: begin
                    if (wcnt_q == WLAST) state_q <= RESP;
                    else                 wcnt_q  <= wcnt_q + 4'd1;
                end
                RESP: begin
                    ready_q    <= 1'b1;
                    mis_q      <= mis_d;
                    data_out_q <= (mis_d || we_q) ? '0 : ld_data_d;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out_o   = data_out_q;
    assign ready_o      = ready_q;
    assign misaligned_o = mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with wait states and one
// with zero wait states, expected values hand-computed.
module tb_dmem_responder;

    localparam int AWL = 10;
    localparam int WC  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_m = 1'b0;
    logic        req_z = 1'b0;
    logic [31:0] addr  = '0;
    logic        we    = 1'b0;
    logic        by    = 1'b0;
    logic        hw    = 1'b0;
    logic        se    = 1'b0;
    logic [31:0] din   = '0;
    logic [31:0] dout_m, dout_z;
    logic        rdy_m, rdy_z, mis_m, mis_z;

    int nchk = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    dmem_responder #(.ADDR_WORDS_LOG2(AWL), .WAIT_CYCLES(WC)) dut (
        .clock(clock), .reset(reset), .req_i(req_m), .addr_i(addr),
        .write_enable_i(we), .byte_i(by), .half_word_i(hw), .sign_extend_i(se),
        .data_in_i(din), .data_out_o(dout_m), .ready_o(rdy_m), .misaligned_o(mis_m)
    );

    dmem_responder #(.ADDR_WORDS_LOG2(AWL), .WAIT_CYCLES(0)) dut_z (
        .clock(clock), .reset(reset), .req_i(req_z), .addr_i(addr),
        .write_enable_i(we), .byte_i(by), .half_word_i(hw), .sign_extend_i(se),
        .data_in_i(din), .data_out_o(dout_z), .ready_o(rdy_z), .misaligned_o(mis_z)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after the response edge.
    task automatic xact(input bit z, input bit w, input bit b, input bit h, input bit s,
                        input logic [31:0] a, input logic [31:0] d, input string tag,
                        input logic [31:0] exp_data, input bit exp_mis);
        int lat;
        bit got;
        addr = a; we = w; by = b; hw = h; se = s; din = d;
        if (z) req_z = 1'b1; else req_m = 1'b1;
        @(posedge clock); #1;
        req_z = 1'b0; req_m = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clock); #1;
            lat++;
            got = z ? rdy_z : rdy_m;
        end
        chk({tag, "_lat"}, got ? lat : -1, z ? 1 : WC + 1);
        if (got) begin
            chk({tag, "_data"}, z ? dout_z : dout_m, exp_data);
            chk({tag, "_mis"}, z ? mis_z : mis_m, {31'd0, exp_mis});
        end
    endtask

    initial begin
        int pulses;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", rdy_m, 0);
        chk("rst_mis", mis_m, 0);
        chk("rst_dout", dout_m, 0);
        chk("rst_ready_z", rdy_z, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        xact(0, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, "st_word", 32'h0, 0);
        xact(0, 0, 0, 0, 0, 32'h10, 32'h0, "ld_word", 32'hDEADBEEF, 0);
        @(posedge clock); #1;
        chk("ready_one_cycle", rdy_m, 0);
        chk("dout_held", dout_m, 32'hDEADBEEF);

        xact(0, 0, 1, 0, 1, 32'h10, 32'h0, "ldb_10", 32'hFFFFFFDE, 0);
        xact(0, 0, 1, 0, 1, 32'h11, 32'h0, "ldb_11", 32'hFFFFFFAD, 0);
        xact(0, 0, 1, 0, 1, 32'h12, 32'h0, "ldb_12", 32'hFFFFFFBE, 0);
        xact(0, 0, 1, 0, 1, 32'h13, 32'h0, "ldb_13", 32'hFFFFFFEF, 0);
        xact(0, 0, 1, 0, 0, 32'h11, 32'h0, "ldbu_11", 32'h000000AD, 0);
        xact(0, 0, 1, 1, 1, 32'h12, 32'h0, "byte_prio", 32'hFFFFFFBE, 0);

        xact(0, 1, 0, 1, 0, 32'h12, 32'h00001234, "st_half", 32'h0, 0);
        xact(0, 0, 0, 0, 0, 32'h10, 32'h0, "ld_after_sth", 32'hDEAD1234, 0);
        xact(0, 0, 0, 1, 1, 32'h10, 32'h0, "ldh_10", 32'hFFFFDEAD, 0);
        xact(0, 0, 0, 1, 1, 32'h12, 32'h0, "ldh_12", 32'h00001234, 0);

        xact(0, 1, 0, 0, 0, 32'h11, 32'hCAFEF00D, "st_word_mis", 32'h0, 1);
        xact(0, 0, 0, 1, 1, 32'h13, 32'h0, "ldh_mis", 32'h0, 1);
        xact(0, 0, 0, 0, 0, 32'h10, 32'h0, "ld_after_mis", 32'hDEAD1234, 0);

        xact(0, 1, 1, 0, 0, 32'h11, 32'hFFFFFF77, "st_byte", 32'h0, 0);
        xact(0, 0, 0, 0, 0, 32'h10, 32'h0, "ld_after_stb", 32'hDE771234, 0);

        // Store aborted by reset while waiting.
        xact(0, 1, 0, 0, 0, 32'h20, 32'h11111111, "st_old", 32'h0, 0);
        addr = 32'h20; we = 1'b1; by = 1'b0; hw = 1'b0; din = 32'h22222222; req_m = 1'b1;
        @(posedge clock); #1;
        req_m = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            pulses += int'(rdy_m);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            pulses += int'(rdy_m);
        end
        chk("abort_pulses", pulses, 0);
        chk("abort_dout", dout_m, 0);
        xact(0, 0, 0, 0, 0, 32'h20, 32'h0, "ld_after_abort", 32'h11111111, 0);

        // req toggled while waiting must not start a second access.
        addr = 32'h20; we = 1'b0; req_m = 1'b1;
        @(posedge clock); #1;
        req_m = 1'b0;
        @(posedge clock); #1;
        req_m = 1'b1;
        @(posedge clock); #1;
        req_m = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            pulses += int'(rdy_m);
        end
        chk("toggle_pulses", pulses, 1);

        xact(0, 1, 0, 0, 0, (32'd4 << AWL) + 32'h8, 32'hA5A5A5A5, "st_wrap", 32'h0, 0);
        xact(0, 0, 0, 0, 0, 32'h8, 32'h0, "ld_wrap", 32'hA5A5A5A5, 0);

        xact(1, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, "z_st_word", 32'h0, 0);
        xact(1, 0, 0, 0, 0, 32'h10, 32'h0, "z_ld_word", 32'hDEADBEEF, 0);
        xact(1, 0, 1, 0, 1, 32'h13, 32'h0, "z_ldb_13", 32'hFFFFFFEF, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
